// File: rtl/dmac_evt_pkg.sv
// Shared constants and types for the DMA termination event buffer.
package dmac_evt_pkg;

  localparam int NB_CORES_DEF  = 8;
  localparam int CNT_WIDTH_DEF = 4;

  typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Target indices that follow the per-core targets.
  localparam int TGT_CL = NB_CORES_DEF;
  localparam int TGT_FC = NB_CORES_DEF + 1;

endpackage

// File: rtl/dmac_evt_counter.sv
// One target's pending-event counter: saturating increment, valid/ready
// decrement and a sticky overflow flag.
module dmac_evt_counter
  import dmac_evt_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 ready_i,
  input  logic                 ovf_clr_i,
  output logic                 valid_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_VAL = '1;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;
  logic                 dec;
  logic                 at_max;
  logic                 ovf_set;

  // Handshake: valid is high whenever the counter is non-zero; one event is
  // consumed on every cycle with valid & ready; ready with valid low is ignored.
  assign valid_o = (cnt_q != '0);
  assign dec     = valid_o & ready_i;
  assign at_max  = (cnt_q == MAX_VAL);
  assign ovf_set = inc_i & ~dec & at_max;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (inc_i && !dec && !at_max) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end else if (!inc_i && dec) begin
        cnt_q <= cnt_q - CNT_WIDTH'(1);
      end
      // A fresh overflow takes priority over a clear in the same cycle.
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr_i);
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/dmac_term_evt_buffer.sv
// Buffers DMA termination pulses into per-target pending counters, registers
// the termination irqs and produces a registered cluster DMA idle flag.
module dmac_term_evt_buffer
  import dmac_evt_pkg::*;
#(
  parameter int NB_CORES   = NB_CORES_DEF,
  parameter int NB_TARGETS = NB_CORES + 2,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NB_TARGETS-1:0]           term_evt_i,
  input  logic [NB_TARGETS-1:0]           term_irq_i,
  input  logic                            dma_busy_i,
  output logic [NB_TARGETS-1:0]           evt_valid_o,
  input  logic [NB_TARGETS-1:0]           evt_ready_i,
  output logic [NB_TARGETS-1:0]           irq_o,
  output logic [NB_TARGETS*CNT_WIDTH-1:0] pending_o,
  output logic [NB_TARGETS-1:0]           ovf_o,
  input  logic [NB_TARGETS-1:0]           ovf_clr_i,
  output logic                            idle_o
);

  logic [NB_TARGETS-1:0] irq_q;
  logic                  idle_q;

  for (genvar i = 0; i < NB_TARGETS; i++) begin : g_tgt
    dmac_evt_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (term_evt_i[i]),
      .ready_i   (evt_ready_i[i]),
      .ovf_clr_i (ovf_clr_i[i]),
      .valid_o   (evt_valid_o[i]),
      .cnt_o     (pending_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .ovf_o     (ovf_o[i])
    );
  end

  // Idle looks at the counter registers, not at this cycle's incoming pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      irq_q  <= term_irq_i;
      idle_q <= ~dma_busy_i & ~(|evt_valid_o);
    end
  end

  assign irq_o  = irq_q;
  assign idle_o = idle_q;

endmodule

// File: tb/tb_dmac_term_evt_buffer.sv
// Scoreboard bench for dmac_term_evt_buffer: directed scenarios plus random
// traffic, checked against a per-target integer count model.
module tb_dmac_term_evt_buffer;
  import dmac_evt_pkg::*;

  localparam int NT = 10;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam int EW = 3*NT + NT*CW + 1;

  logic                clk;
  logic                rst_i;
  logic [NT-1:0]       term_evt_i;
  logic [NT-1:0]       term_irq_i;
  logic                dma_busy_i;
  logic [NT-1:0]       evt_valid_o;
  logic [NT-1:0]       evt_ready_i;
  logic [NT-1:0]       irq_o;
  logic [NT*CW-1:0]    pending_o;
  logic [NT-1:0]       ovf_o;
  logic [NT-1:0]       ovf_clr_i;
  logic                idle_o;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  int m_cnt[NT];
  bit m_ovf[NT];

  dmac_term_evt_buffer dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .term_evt_i  (term_evt_i),
    .term_irq_i  (term_irq_i),
    .dma_busy_i  (dma_busy_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .irq_o       (irq_o),
    .pending_o   (pending_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i),
    .idle_o      (idle_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs and push the model's post-edge outputs
  task automatic cycle(input logic [NT-1:0] evt, input logic [NT-1:0] irq,
                       input logic [NT-1:0] rdy, input logic [NT-1:0] clr,
                       input logic busy);
    logic [NT-1:0]    e_valid;
    logic [NT-1:0]    e_ovf;
    logic [NT*CW-1:0] e_pend;
    logic [CW-1:0]    c;
    logic             e_idle;
    bit               accept;
    bit               set;
    @(negedge clk);
    term_evt_i  = evt;
    term_irq_i  = irq;
    evt_ready_i = rdy;
    ovf_clr_i   = clr;
    dma_busy_i  = busy;
    e_idle = !busy;
    for (int i = 0; i < NT; i++) if (m_cnt[i] != 0) e_idle = 1'b0;
    for (int i = 0; i < NT; i++) begin
      accept = (m_cnt[i] > 0) && rdy[i];
      set    = 1'b0;
      if (evt[i] && !accept) begin
        if (m_cnt[i] == MAXC) set = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end else if (!evt[i] && accept) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
      m_ovf[i] = set || (m_ovf[i] && !clr[i]);
      c = CW'(m_cnt[i]);
      e_pend[i*CW +: CW] = c;
      e_valid[i] = (m_cnt[i] != 0);
      e_ovf[i]   = m_ovf[i];
    end
    exp_q.push_back({e_valid, irq, e_ovf, e_pend, e_idle});
  endtask

  task automatic idle_cycles(input int n, input logic busy);
    for (int k = 0; k < n; k++) cycle('0, '0, '0, '0, busy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},   64'(evt_valid_o), 64'(0));
    chk({tag, "_pending"}, 64'(pending_o),   64'(0));
    chk({tag, "_ovf"},     64'(ovf_o),       64'(0));
    chk({tag, "_irq"},     64'(irq_o),       64'(0));
    chk({tag, "_idle"},    64'(idle_o),      64'(1));
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst_i = 1'b1;
    term_evt_i = '0; term_irq_i = '0; evt_ready_i = '0; ovf_clr_i = '0; dma_busy_i = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    for (int i = 0; i < NT; i++) begin m_cnt[i] = 0; m_ovf[i] = 1'b0; end
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Monitor: pop and compare one expectation after every active edge
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("valid",   64'(evt_valid_o), 64'(e[EW-1 -: NT]));
        chk("irq",     64'(irq_o),       64'(e[EW-NT-1 -: NT]));
        chk("ovf",     64'(ovf_o),       64'(e[EW-2*NT-1 -: NT]));
        chk("pending", 64'(pending_o),   64'(e[NT*CW:1]));
        chk("idle",    64'(idle_o),      64'(e[0]));
      end
    end
  end

  // Stimulus
  initial begin
    logic [NT-1:0] b3, b0, b9, b1, b8, b2;
    logic [NT-1:0] r_evt, r_irq, r_rdy, r_clr;
    int p_evt, p_rdy;
    b3 = NT'(1) << 3; b0 = NT'(1) << 0; b9 = NT'(1) << TGT_FC;
    b1 = NT'(1) << 1; b8 = NT'(1) << TGT_CL; b2 = NT'(1) << 2;
    for (int i = 0; i < NT; i++) begin m_cnt[i] = 0; m_ovf[i] = 1'b0; end
    rst_i = 1'b1;
    term_evt_i = '0; term_irq_i = '0; evt_ready_i = '0; ovf_clr_i = '0; dma_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("por");

    // Single pulse on target 3, accepted a few cycles later
    idle_cycles(6, 1'b0);
    cycle(b3, '0, '0, '0, 1'b0);
    idle_cycles(2, 1'b0);
    cycle('0, '0, b3, '0, 1'b0);
    idle_cycles(2, 1'b0);

    // Five pulses on target 0 then drained back-to-back
    for (int k = 0; k < 5; k++) cycle(b0, '0, '0, '0, 1'b0);
    for (int k = 0; k < 6; k++) cycle('0, '0, b0, '0, 1'b0);

    // Simultaneous inc/dec on FC at 2 and at saturation
    for (int k = 0; k < 2; k++) cycle(b9, '0, '0, '0, 1'b0);
    cycle(b9, '0, b9, '0, 1'b0);
    for (int k = 0; k < 13; k++) cycle(b9, '0, '0, '0, 1'b0);
    cycle(b9, '0, b9, '0, 1'b0);
    for (int k = 0; k < MAXC; k++) cycle('0, '0, b9, '0, 1'b0);

    // Saturation, overflow, clear, and clear losing to a new overflow
    for (int k = 0; k < 16; k++) cycle(b1, '0, '0, '0, 1'b0);
    cycle('0, '0, '0, b1, 1'b0);
    cycle(b1, '0, '0, '0, 1'b0);
    cycle(b1, '0, '0, b1, 1'b0);
    cycle('0, '0, '0, '0, 1'b0);
    for (int k = 0; k < MAXC; k++) cycle('0, '0, b1, b1, 1'b0);

    // Consecutive irq pulses on cluster ctrl
    cycle('0, b8, '0, '0, 1'b0);
    cycle('0, b8, '0, '0, 1'b0);
    idle_cycles(2, 1'b0);

    // Idle tracking with busy and a pending event, then async reset
    cycle('0, '0, '0, '0, 1'b1);
    cycle(b2, '0, '0, '0, 1'b1);
    idle_cycles(2, 1'b0);
    cycle('0, '0, b2, '0, 1'b0);
    idle_cycles(3, 1'b0);
    for (int k = 0; k < 4; k++) cycle(b2, '0, '0, '0, 1'b0);
    mid_reset();
    idle_cycles(3, 1'b0);

    // Random traffic with varying pressure
    for (int ph = 0; ph < 8; ph++) begin
      p_evt = $urandom_range(10, 90);
      p_rdy = (ph % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(20, 100);
      for (int k = 0; k < 250; k++) begin
        for (int i = 0; i < NT; i++) begin
          r_evt[i] = ($urandom_range(0, 99) < p_evt);
          r_irq[i] = ($urandom_range(0, 99) < 30);
          r_rdy[i] = ($urandom_range(0, 99) < p_rdy);
          r_clr[i] = ($urandom_range(0, 99) < 5);
        end
        cycle(r_evt, r_irq, r_rdy, r_clr, 1'($urandom_range(0, 3) == 0));
      end
      if (ph % 4 == 3) mid_reset();
    end
    idle_cycles(2, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
